// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
// Contents: sequencer state enum and the full stream-length helper.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sc_seq_state_t;

  // Full LFSR period for a WIDTH-bit generator.
  function automatic int unsigned full_len(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// WIDTH-bit counter with synchronous clear and a 1-bit increment.
// Ports: clk, rst_n (async active-low), clr (sync clear, has priority),
//        en (advance enable), inc (bit added when enabled), count (value).
module sc_ones_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(inc);
    end
  end

endmodule

// File: rtl/sc_sng_sequencer.sv
// Run controller for the LFSR SNG bank: accepts one job, reseeds and runs
// the SNG bank for the target length, counts ones on z_bit and returns
// the ones count and cycles used on a valid/ready result port.
// Ports: clk, rst_n; in_valid/in_ready/in_bxs[/in_len] job request;
//        sng_bxs/sng_clr/sng_en SNG bank control; z_bit SC output bit;
//        out_valid/out_ready/out_count/out_len result; busy status.
// Build option: SC_EARLY_TERM_EN adds in_len and et_stop; without it
//        every job runs the full 2^WIDTH-1 cycles.
module sc_sng_sequencer
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_bxs,
`ifdef SC_EARLY_TERM_EN
  input  logic [WIDTH-1:0]            in_len,
  input  logic                        et_stop,
`endif
  output logic [NUM_INPUTS*WIDTH-1:0] sng_bxs,
  output logic                        sng_clr,
  output logic                        sng_en,
  input  logic                        z_bit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_count,
  output logic [WIDTH-1:0]            out_len,
  output logic                        busy
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(full_len(WIDTH));

  sc_seq_state_t    state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] cyc;
  logic             last_c;

  // Target length and end-of-run detection.
`ifdef SC_EARLY_TERM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= FULL;
    end else if (state == IDLE && in_valid) begin
      target <= (in_len == '0) ? FULL : in_len;
    end
  end

  assign last_c = (cyc == target - WIDTH'(1)) || et_stop;
`else
  assign target = FULL;
  assign last_c = (cyc == target - WIDTH'(1));
`endif

  // Control FSM; all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      sng_clr   <= 1'b0;
      sng_en    <= 1'b0;
      out_valid <= 1'b0;
      sng_bxs   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sng_bxs  <= in_bxs;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            sng_clr  <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          sng_clr <= 1'b0;
          sng_en  <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          // The final cycle still counts; the counters see sng_en high.
          if (last_c) begin
            sng_en    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ones on z_bit; frozen outside RUN so it doubles as the result field.
  sc_ones_counter #(.WIDTH(WIDTH)) u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sng_clr),
    .en    (sng_en),
    .inc   (z_bit),
    .count (out_count)
  );

  // Cycles run; also the result length.
  sc_ones_counter #(.WIDTH(WIDTH)) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sng_clr),
    .en    (sng_en),
    .inc   (1'b1),
    .count (cyc)
  );

  assign out_len = cyc;

endmodule

// File: doc/sc_sng_sequencer.md
# sc_sng_sequencer

Run controller for the LFSR stochastic number generator (SNG) bank in the early-termination SC datapath. It accepts one job at a time: NUM_INPUTS binary operands plus an optional stream length. It reseeds the SNG bank, enables it for the required number of cycles and counts the ones on the downstream SC circuit's output bit. It then returns the ones count and the cycles used through a valid/ready result port.

## Interface
- WIDTH, 8, operand, LFSR and counter width; full stream length is 2^WIDTH-1 cycles
- NUM_INPUTS, 8, number of SNG lanes driven
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  job request
- in_ready  output  1  job accept; high only in IDLE
- in_bxs  input  [WIDTH-1:0] x NUM_INPUTS  binary operands
- in_len  input  WIDTH  requested stream length; 0 = full length
- sng_bxs  output  [WIDTH-1:0] x NUM_INPUTS  operands held to the SNG bank for the whole job
- sng_clr  output  1  one-cycle synchronous reseed of all LFSRs to state 1
- sng_en  output  1  SNG advance enable
- z_bit  input  1  SC circuit output bit; valid in any cycle with sng_en=1
- out_valid  output  1  result valid
- out_ready  input  1  result accept
- out_count  output  WIDTH  ones counted on z_bit
- out_len  output  WIDTH  cycles actually run
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE: in_ready=1. On in_valid, register in_bxs into sng_bxs and latch target = (in_len==0 ? 2^WIDTH-1 : in_len), then go to CLR.
- CLR: sng_clr=1 for exactly one cycle. Clear the ones and cycle counters. Go to RUN.
- RUN: sng_en=1 every cycle. On each cycle, cyc += 1 and ones += z_bit. In the cycle where cyc == target-1, perform the final count update and go to DONE.
- DONE: out_valid=1. out_count and out_len hold stable until out_ready. On out_valid && out_ready, go to IDLE.
- Arithmetic: counters are WIDTH bits wide and cannot overflow, because target ≤ 2^WIDTH-1. out_count ≤ out_len always.
- in_valid outside IDLE is ignored and the request is not consumed. out_ready outside DONE is ignored.
- sng_bxs keep their value after the job until the next accept.
- rst_n low at any time, including mid-RUN: state goes to IDLE immediately.
- Reset values: in_ready=1, busy=0, sng_clr=0, sng_en=0, out_valid=0, out_count=0, out_len=0, sng_bxs all 0.

## Timing
- Accept edge is cycle 0. CLR occupies cycle 1. RUN occupies cycles 2 to target+1. out_valid rises at cycle target+2.
- Job-to-result latency: target+2 cycles. A back-to-back job can be accepted at the earliest 1 cycle after the result handshake, since IDLE lasts at least 1 cycle.
- z_bit is sampled combinationally from the SNG in the same cycle as sng_en; there is no added pipeline stage.
- out_valid and all result fields are registered; none have a combinational path from in_* or z_bit.

## Configuration
- SC_EARLY_TERM_EN defined:
  - in_len is honoured as described above.
  - An early-stop request is added: the input et_stop (1 bit, sampled only in RUN) ends the run after the current cycle's count update.
  - out_len reports the true number of cycles run.
- Not defined:
  - in_len and the et_stop port are absent.
  - Every job runs the full 2^WIDTH-1 cycles, and out_len is constant 2^WIDTH-1.

## Structure
- Shared package sc_pkg holds:
  - the state enum sc_seq_state_t {IDLE, CLR, RUN, DONE};
  - the function full_len(WIDTH) = 2^WIDTH-1.
- One sub-module, sc_ones_counter: WIDTH-bit synchronous clear, enable, bit-increment counter, instantiated twice (ones count and cycle count).
- The FSM and handshakes stay in the top module.

## Test plan
- Reset, then idle 5 cycles -> in_ready=1, busy=0, out_valid=0, sng_en=0, all result fields 0.
- WIDTH=8, in_len=0, z_bit tied 1 -> sng_clr pulses once at cycle 1; sng_en high for 255 cycles; out_valid at cycle 257; out_count=255, out_len=255.
- in_len=16, z_bit alternating 1,0 starting with 1 -> out_count=8, out_len=16. Hold out_ready=0 for 10 cycles -> fields stable; then handshake -> back in IDLE next cycle.
- in_valid held high through a whole job -> exactly one accept per job; second job accepted only after the result handshake.
- rst_n asserted at RUN cycle 5 -> all outputs at reset values. A new job then runs from sng_clr with counters zeroed.
- SC_EARLY_TERM_EN defined, in_len=100, z_bit=1, et_stop pulsed at RUN cycle 20 -> out_len=20, out_count=20.
